// File: rtl/multi_dataflow_tcdm_slice_if.sv
// Engine-side and interconnect-side TCDM signals of the MP-channel retiming slice.
// Latency: none (wiring only). Backpressure: carried by in_gnt / tcdm_gnt.
// master = engine + interconnect environment, slave = the slice itself.
interface multi_dataflow_tcdm_slice_if #(
    parameter int unsigned MP = 3,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned BW = DW / 8;

    logic [MP-1:0]          in_req;
    logic [MP-1:0]          in_gnt;
    logic [MP-1:0][AW-1:0]  in_add;
    logic [MP-1:0]          in_wen;
    logic [MP-1:0][BW-1:0]  in_be;
    logic [MP-1:0][DW-1:0]  in_data;
    logic [MP-1:0][DW-1:0]  in_r_data;
    logic [MP-1:0]          in_r_valid;

    logic [MP-1:0]          tcdm_req;
    logic [MP-1:0]          tcdm_gnt;
    logic [MP-1:0][AW-1:0]  tcdm_add;
    logic [MP-1:0]          tcdm_wen;
    logic [MP-1:0][BW-1:0]  tcdm_be;
    logic [MP-1:0][DW-1:0]  tcdm_data;
    logic [MP-1:0][DW-1:0]  tcdm_r_data;
    logic [MP-1:0]          tcdm_r_valid;

    modport master (
        output in_req, in_add, in_wen, in_be, in_data,
        output tcdm_gnt, tcdm_r_data, tcdm_r_valid,
        input  in_gnt, in_r_data, in_r_valid,
        input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data
    );

    modport slave (
        input  in_req, in_add, in_wen, in_be, in_data,
        input  tcdm_gnt, tcdm_r_data, tcdm_r_valid,
        output in_gnt, in_r_data, in_r_valid,
        output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data
    );
endinterface

// File: rtl/multi_dataflow_tcdm_slice.sv
// MP-channel TCDM retiming slice: 1-entry request buffer, registered response, outstanding limiter.
// Latency: request +1 cycle, response +1 cycle. Backpressure: in_gnt low while buffer stuck or MAX_OUTST reached.
// Optional stall counters enabled by MULTI_DATAFLOW_TCDM_PERF_EN; otherwise stall_cnt_o is tied to zero.
module multi_dataflow_tcdm_slice #(
    parameter  int unsigned MP        = 3,
    parameter  int unsigned AW        = 32,
    parameter  int unsigned DW        = 32,
    parameter  int unsigned MAX_OUTST = 4,
    localparam int unsigned BW        = DW / 8,
    localparam int unsigned OW        = $clog2(MAX_OUTST + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    multi_dataflow_tcdm_slice_if.slave bus,
    output logic [MP-1:0]              idle_o,
    output logic [MP-1:0]              err_o,
    output logic [MP-1:0][31:0]        stall_cnt_o
);

    localparam logic [OW:0] MAX_V = MAX_OUTST[OW:0];

    logic [MP-1:0]          r_buf_vld;
    logic [MP-1:0][AW-1:0]  r_buf_add;
    logic [MP-1:0]          r_buf_wen;
    logic [MP-1:0][BW-1:0]  r_buf_be;
    logic [MP-1:0][DW-1:0]  r_buf_data;
    logic [MP-1:0][OW-1:0]  r_cnt;
    logic [MP-1:0]          r_rvalid;
    logic [MP-1:0][DW-1:0]  r_rdata;
    logic [MP-1:0]          r_err;

    logic [MP-1:0]          w_issue;
    logic [MP-1:0]          w_cnt_ok;
    logic [MP-1:0]          w_cnt_zero;
    logic [MP-1:0]          w_gnt;
    logic [MP-1:0]          w_accept;

    assign w_issue  = r_buf_vld & bus.tcdm_gnt;
    assign w_gnt    = (~r_buf_vld | bus.tcdm_gnt) & w_cnt_ok;
    assign w_accept = bus.in_req & w_gnt;

    // The request issued this cycle counts against the limit, so in_gnt sees it combinationally.
    always_comb begin
        w_cnt_ok   = '0;
        w_cnt_zero = '0;
        for (int unsigned ii = 0; ii < MP; ii++) begin
            w_cnt_ok[ii]   = ({1'b0, r_cnt[ii]} + {{OW{1'b0}}, w_issue[ii]}) < MAX_V;
            w_cnt_zero[ii] = (r_cnt[ii] == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buf_vld  <= '0;
            r_buf_add  <= '0;
            r_buf_wen  <= '0;
            r_buf_be   <= '0;
            r_buf_data <= '0;
        end else begin
            for (int unsigned ii = 0; ii < MP; ii++) begin
                if (w_accept[ii]) begin
                    r_buf_vld[ii]  <= 1'b1;
                    r_buf_add[ii]  <= bus.in_add[ii];
                    r_buf_wen[ii]  <= bus.in_wen[ii];
                    r_buf_be[ii]   <= bus.in_be[ii];
                    r_buf_data[ii] <= bus.in_data[ii];
                end else if (w_issue[ii]) begin
                    r_buf_vld[ii]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= bus.tcdm_r_valid;
            for (int unsigned ii = 0; ii < MP; ii++) begin
                if (bus.tcdm_r_valid[ii]) begin
                    r_rdata[ii] <= bus.tcdm_r_data[ii];
                end
            end
        end
    end

    // A response with nothing outstanding is flagged and never underflows the counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_err <= '0;
        end else begin
            for (int unsigned ii = 0; ii < MP; ii++) begin
                if (w_issue[ii] && !r_rvalid[ii]) begin
                    r_cnt[ii] <= r_cnt[ii] + OW'(1);
                end else if (!w_issue[ii] && r_rvalid[ii] && !w_cnt_zero[ii]) begin
                    r_cnt[ii] <= r_cnt[ii] - OW'(1);
                end

                if (r_rvalid[ii] && w_cnt_zero[ii]) begin
                    r_err[ii] <= 1'b1;
                end else if (clear_i) begin
                    r_err[ii] <= 1'b0;
                end
            end
        end
    end

`ifdef MULTI_DATAFLOW_TCDM_PERF_EN
    logic [MP-1:0][31:0] r_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall <= '0;
        end else begin
            for (int unsigned ii = 0; ii < MP; ii++) begin
                if (clear_i) begin
                    r_stall[ii] <= '0;
                end else if (r_buf_vld[ii] && !bus.tcdm_gnt[ii] && (r_stall[ii] != 32'hFFFF_FFFF)) begin
                    r_stall[ii] <= r_stall[ii] + 32'd1;
                end
            end
        end
    end

    assign stall_cnt_o = r_stall;
`else
    assign stall_cnt_o = '0;
`endif

    assign bus.in_gnt     = w_gnt;
    assign bus.in_r_valid = r_rvalid;
    assign bus.in_r_data  = r_rdata;
    assign bus.tcdm_req   = r_buf_vld;
    assign bus.tcdm_add   = r_buf_add;
    assign bus.tcdm_wen   = r_buf_wen;
    assign bus.tcdm_be    = r_buf_be;
    assign bus.tcdm_data  = r_buf_data;

    assign idle_o = ~r_buf_vld & w_cnt_zero & ~r_rvalid;
    assign err_o  = r_err;

endmodule
